// File: rtl/instr_mem_pkg.sv
// Shared types and address helpers for the instruction fetch memory.
package instr_mem_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   function automatic int unsigned bytes_per_word(input int unsigned instr_w);
      return instr_w / 8;
   endfunction

   // Instruction words are 16 or 32 bits, so the byte offset is 1 or 2 bits wide.
   function automatic logic [31:0] word_idx(input logic [31:0] addr, input int unsigned instr_w);
      return (bytes_per_word(instr_w) == 4) ? (addr >> 2) : (addr >> 1);
   endfunction

   function automatic logic is_aligned(input logic [31:0] addr, input int unsigned instr_w);
      return (addr & 32'(bytes_per_word(instr_w) - 1)) == 32'd0;
   endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port, no reset.
module instr_mem_array #(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned DEPTH   = 128,
   parameter int unsigned IDX_W   = 7
) (
   input  logic               clk,
   input  logic               we,
   input  logic [IDX_W-1:0]   waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [IDX_W-1:0]   raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_mem.sv
// IF-stage instruction memory: registered fetch with stall/flush, fault flags,
// program-load port and an optional post-reset clear sweep.
module instr_fetch_mem
   import instr_mem_pkg::*;
#(
   parameter int unsigned          ADDR_W     = 8,
   parameter int unsigned          INSTR_W    = 16,
   parameter int unsigned          DEPTH      = 128,
   parameter logic [INSTR_W-1:0]   NOP_WORD   = '0,
   parameter int unsigned          INIT_CLEAR = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_req,
   input  logic [ADDR_W-1:0]  fetch_addr,
   input  logic               stall,
   input  logic               flush,
   input  logic               prog_we,
   input  logic [ADDR_W-1:0]  prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   output logic               ready,
   output logic [INSTR_W-1:0] inst_out,
   output logic               inst_valid,
   output logic               misalign,
   output logic               oob
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic               ready_d, valid_d, mis_d, oob_d;
   logic [INSTR_W-1:0] out_d;

   logic [31:0]        f_idx, p_idx;
   logic               f_align, f_in, p_ok, bypass;
   logic               mem_we;
   logic [IDX_W-1:0]   mem_waddr;
   logic [INSTR_W-1:0] mem_wdata, rdata, fetch_data;

   // Address decode; indices at or beyond DEPTH are faults, never aliases.
   always_comb begin
      f_idx      = word_idx(32'(fetch_addr), INSTR_W);
      p_idx      = word_idx(32'(prog_addr), INSTR_W);
      f_align    = is_aligned(32'(fetch_addr), INSTR_W);
      f_in       = f_idx < DEPTH;
      p_ok       = ready && prog_we && is_aligned(32'(prog_addr), INSTR_W) && (p_idx < DEPTH);
      bypass     = p_ok && (p_idx == f_idx);
      fetch_data = bypass ? prog_data : rdata;
   end

   instr_mem_array #(
      .INSTR_W (INSTR_W),
      .DEPTH   (DEPTH),
      .IDX_W   (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (IDX_W'(f_idx)),
      .rdata (rdata)
   );

   // Next state, write mux and output-register next values.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ready_d   = ready;
      out_d     = inst_out;
      valid_d   = inst_valid;
      mis_d     = misalign;
      oob_d     = oob;
      mem_we    = 1'b0;
      mem_waddr = IDX_W'(p_idx);
      mem_wdata = prog_data;

      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = NOP_WORD;
            cnt_d     = cnt_q + IDX_W'(1);
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
            end
         end
         ST_RUN: begin
            ready_d = 1'b1;
            mem_we  = p_ok;
         end
         default: state_d = ST_RUN;
      endcase

      // Flush beats stall; stall freezes every output register.
      if (flush) begin
         valid_d = 1'b0;
         mis_d   = 1'b0;
         oob_d   = 1'b0;
      end else if (!stall) begin
         if (ready && fetch_req) begin
            mis_d = !f_align;
            oob_d = !f_in;
            if (!f_align || !f_in) begin
               out_d   = NOP_WORD;
               valid_d = 1'b0;
            end else begin
               out_d   = fetch_data;
               valid_d = 1'b1;
            end
         end else begin
            valid_d = 1'b0;
            mis_d   = 1'b0;
            oob_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
         cnt_q      <= '0;
         ready      <= 1'b0;
         inst_out   <= NOP_WORD;
         inst_valid <= 1'b0;
         misalign   <= 1'b0;
         oob        <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ready      <= ready_d;
         inst_out   <= out_d;
         inst_valid <= valid_d;
         misalign   <= mis_d;
         oob        <= oob_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: three configurations share one stimulus stream and
// are each checked against a word-array model every cycle, plus literal checks.
module tb_instr_fetch_mem;

   logic        clk = 1'b0;
   logic        rst, fetch_req, stall, flush, prog_we;
   logic [7:0]  fetch_addr, prog_addr;
   logic [31:0] prog_data;

   logic        a_rdy [3];
   logic        a_val [3];
   logic        a_mis [3];
   logic        a_oob [3];
   logic [31:0] a_out [3];
   logic [15:0] o0, o1;
   logic [31:0] o2;

   always #5 clk = ~clk;

   assign a_out[0] = {16'h0, o0};
   assign a_out[1] = {16'h0, o1};
   assign a_out[2] = o2;

   instr_fetch_mem #(.ADDR_W(8), .INSTR_W(16), .DEPTH(128), .NOP_WORD(16'h0), .INIT_CLEAR(1)) u0 (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
      .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data[15:0]),
      .ready(a_rdy[0]), .inst_out(o0), .inst_valid(a_val[0]), .misalign(a_mis[0]), .oob(a_oob[0]));

   instr_fetch_mem #(.ADDR_W(8), .INSTR_W(16), .DEPTH(64), .NOP_WORD(16'h0), .INIT_CLEAR(1)) u1 (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
      .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data[15:0]),
      .ready(a_rdy[1]), .inst_out(o1), .inst_valid(a_val[1]), .misalign(a_mis[1]), .oob(a_oob[1]));

   instr_fetch_mem #(.ADDR_W(8), .INSTR_W(32), .DEPTH(48), .NOP_WORD(32'h0), .INIT_CLEAR(1)) u2 (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
      .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .ready(a_rdy[2]), .inst_out(o2), .inst_valid(a_val[2]), .misalign(a_mis[2]), .oob(a_oob[2]));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: per-configuration word arrays and expected outputs.
   int          depth [3] = '{128, 64, 48};
   int          bpw   [3] = '{2, 2, 4};
   logic [31:0] mask  [3] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};
   logic [31:0] mmem  [3][128];
   int          left  [3];
   logic        e_rdy [3];
   logic        e_val [3];
   logic        e_mis [3];
   logic        e_oob [3];
   logic [31:0] e_out [3];
   logic        model_on = 1'b0;

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            e_out[k] = 32'h0; e_val[k] = 1'b0; e_mis[k] = 1'b0; e_oob[k] = 1'b0;
            e_rdy[k] = 1'b0;  left[k] = depth[k];
         end else begin
            automatic logic rdy_now = e_rdy[k];
            automatic int   pidx    = int'(prog_addr) / bpw[k];
            automatic int   fidx    = int'(fetch_addr) / bpw[k];
            automatic logic fmis    = (int'(fetch_addr) % bpw[k]) != 0;
            automatic logic foob    = fidx >= depth[k];
            if (left[k] > 0) begin
               mmem[k][depth[k] - left[k]] = 32'h0;
               left[k]--;
            end
            e_rdy[k] = (left[k] == 0);
            if (rdy_now && prog_we && (int'(prog_addr) % bpw[k]) == 0 && pidx < depth[k])
               mmem[k][pidx] = prog_data & mask[k];
            if (flush) begin
               e_val[k] = 1'b0; e_mis[k] = 1'b0; e_oob[k] = 1'b0;
            end else if (!stall) begin
               if (rdy_now && fetch_req) begin
                  e_mis[k] = fmis;
                  e_oob[k] = foob;
                  e_val[k] = !(fmis || foob);
                  e_out[k] = (fmis || foob) ? 32'h0 : mmem[k][fidx];
               end else begin
                  e_val[k] = 1'b0; e_mis[k] = 1'b0; e_oob[k] = 1'b0;
               end
            end
         end
      end
      if (rst) model_on = 1'b1;
   end

   always @(negedge clk) begin
      if (model_on) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.ready", k),      32'(a_rdy[k]), 32'(e_rdy[k]));
            chk($sformatf("u%0d.inst_valid", k), 32'(a_val[k]), 32'(e_val[k]));
            chk($sformatf("u%0d.misalign", k),   32'(a_mis[k]), 32'(e_mis[k]));
            chk($sformatf("u%0d.oob", k),        32'(a_oob[k]), 32'(e_oob[k]));
            chk($sformatf("u%0d.inst_out", k),   a_out[k],      e_out[k]);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle();
      fetch_req = 1'b0; stall = 1'b0; flush = 1'b0; prog_we = 1'b0;
   endtask

   // Releases reset and counts edges until each configuration reports ready.
   task automatic release_and_count(output int n0, output int n1, output int n2);
      int n = 0;
      n0 = -1; n1 = -1; n2 = -1;
      rst = 1'b0;
      while ((n0 < 0 || n1 < 0 || n2 < 0) && n < 400) begin
         tick(); n++;
         if (a_rdy[0] && n0 < 0) n0 = n;
         if (a_rdy[1] && n1 < 0) n1 = n;
         if (a_rdy[2] && n2 < 0) n2 = n;
      end
   endtask

   task automatic fetch(input logic [7:0] a);
      fetch_req = 1'b1; fetch_addr = a; tick();
   endtask

   initial begin
      int n0, n1, n2;
      rst = 1'b1; fetch_addr = 8'h0; prog_addr = 8'h0; prog_data = 32'h0;
      idle();
      tick(2);
      chk("reset_ready", 32'(a_rdy[0]), 32'h0);
      chk("reset_valid", 32'(a_val[0]), 32'h0);
      release_and_count(n0, n1, n2);
      chk("clear_len_128", 32'(n0), 32'd128);
      chk("clear_len_64",  32'(n1), 32'd64);
      chk("clear_len_48",  32'(n2), 32'd48);

      fetch(8'd0);
      chk("fetch0_out", a_out[0], 32'h0);
      chk("fetch0_valid", 32'(a_val[0]), 32'h1);

      fetch_req = 1'b0; prog_we = 1'b1;
      prog_addr = 8'd0; prog_data = 32'hA1B2; tick();
      prog_addr = 8'd2; prog_data = 32'hC3D4; tick();
      prog_addr = 8'd4; prog_data = 32'hE5F6; tick();
      prog_we = 1'b0;
      fetch(8'd0); chk("prog_fetch0", a_out[0], 32'hA1B2);
      fetch(8'd2); chk("prog_fetch2", a_out[0], 32'hC3D4);
      fetch(8'd4); chk("prog_fetch4", a_out[0], 32'hE5F6);

      fetch(8'd3);
      chk("mis3_flag", 32'(a_mis[0]), 32'h1);
      chk("mis3_valid", 32'(a_val[0]), 32'h0);
      chk("mis3_out", a_out[0], 32'h0);
      fetch(8'd254);
      chk("oob254_d64", 32'(a_oob[1]), 32'h1);
      chk("oob254_d128", 32'(a_oob[0]), 32'h0);
      chk("both_faults_mis", 32'(a_mis[2]), 32'h1);
      chk("both_faults_oob", 32'(a_oob[2]), 32'h1);

      fetch(8'd2);
      stall = 1'b1; fetch_addr = 8'd4;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_out", a_out[0], 32'hC3D4);
         chk("stall_valid", 32'(a_val[0]), 32'h1);
      end
      flush = 1'b1; tick();
      chk("flush_valid", 32'(a_val[0]), 32'h0);
      idle(); tick();

      prog_we = 1'b1; prog_addr = 8'd6; prog_data = 32'h1234;
      fetch(8'd6);
      chk("bypass_out", a_out[0], 32'h1234);
      chk("bypass_valid", 32'(a_val[0]), 32'h1);
      idle();

      prog_we = 1'b1; prog_addr = 8'd4; prog_data = 32'hDEADBEEF; tick();
      prog_we = 1'b0;
      fetch(8'd4); chk("w32_fetch4", a_out[2], 32'hDEADBEEF);
      fetch(8'd2);
      chk("w32_mis2", 32'(a_mis[2]), 32'h1);
      chk("w32_mis2_valid", 32'(a_val[2]), 32'h0);
      idle();

      for (int i = 0; i < 2000; i++) begin
         fetch_req  = ($urandom_range(0, 3) != 0);
         fetch_addr = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
         stall      = ($urandom_range(0, 7) == 0);
         flush      = ($urandom_range(0, 15) == 0);
         prog_we    = ($urandom_range(0, 3) == 0);
         prog_addr  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
         prog_data  = $urandom;
         tick();
      end
      idle();

      rst = 1'b1; tick();
      rst = 1'b0; tick(50);
      chk("midclear_ready", 32'(a_rdy[0]), 32'h0);
      rst = 1'b1; tick();
      chk("midclear_rst_ready", 32'(a_rdy[0]), 32'h0);
      release_and_count(n0, n1, n2);
      chk("restart_len_128", 32'(n0), 32'd128);
      chk("restart_len_48",  32'(n2), 32'd48);

      for (int i = 0; i < 200; i++) begin
         fetch_req  = $urandom_range(0, 1) != 0;
         fetch_addr = 8'($urandom_range(0, 31));
         prog_we    = $urandom_range(0, 2) == 0;
         prog_addr  = 8'($urandom_range(0, 31));
         prog_data  = $urandom;
         tick();
      end
      idle(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
